// File: rtl/layer_seq_ctrl.sv
// layer_seq_ctrl: layer sequencer for the ping-pong ifmap/result buffer and
// the img2col GEMM engine. Tracks the initial DMA load, issues one conv_en
// pulse per layer, waits for the engine's conv_done, mirrors which bank is
// the tensor source, and grants DMA readback of the final result bank.
//
// Ports:
//   clk, rstn        clock; synchronous active-high reset (asserted = 1)
//   enable           global enable; state/counters/err advance only when 1
//   start            begin a run (num_layers sampled on acceptance)
//   num_layers       layers to execute
//   load_last        DMA accepted the last input beat
//   conv_done        engine finished the current layer
//   rd_req, rd_last  DMA readback request level / last readback beat
//   w_done           pulse: input load complete
//   conv_en          pulse: start a layer / swap banks
//   src_bank         bank read as tensor source (result bank is ~src_bank)
//   layer_idx        index of the running layer
//   busy             high from accepted start until return to IDLE
//   rd_grant         readback permitted
//   done             pulse: all layers computed
//   err              sticky protocol-violation flag
module layer_seq_ctrl #(
  parameter int unsigned LAYER_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               start,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic               load_last,
  input  logic               conv_done,
  input  logic               rd_req,
  input  logic               rd_last,
  output logic               w_done,
  output logic               conv_en,
  output logic               src_bank,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               rd_grant,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LOADED = 3'd2,
    S_KICK   = 3'd3,
    S_RUN    = 3'd4,
    S_FIN    = 3'd5,
    S_RDWAIT = 3'd6
  } state_t;

  state_t             state;
  logic [LAYER_W-1:0] layer_cnt;

  // Sequencer state, counters and registered outputs. Pulse outputs are
  // decoded from the state they belong to, so a stalled pulse is issued once
  // on the first enabled cycle in that state.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= S_IDLE;
      layer_cnt <= '0;
      layer_idx <= '0;
      src_bank  <= 1'b0;
      w_done    <= 1'b0;
      conv_en   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      rd_grant  <= 1'b0;
      err       <= 1'b0;
    end else begin
      w_done  <= 1'b0;
      conv_en <= 1'b0;
      done    <= 1'b0;
      if (enable) begin
        // Protocol violations never change the state.
        if ((start && (state != S_IDLE) && (state != S_RDWAIT)) ||
            (conv_done && (state != S_RUN)) ||
            (load_last && (state != S_LOAD)) ||
            (rd_last && !rd_grant)) begin
          err <= 1'b1;
        end

        case (state)
          // A start in RDWAIT abandons the readback and behaves like IDLE.
          S_IDLE, S_RDWAIT: begin
            if (start) begin
              rd_grant <= 1'b0;
              if (num_layers != '0) begin
                layer_cnt <= num_layers;
                layer_idx <= '0;
                busy      <= 1'b1;
                state     <= S_LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else if (state == S_RDWAIT) begin
              if (rd_grant && rd_last) begin
                rd_grant <= 1'b0;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end else if (rd_req) begin
                rd_grant <= 1'b1;
              end
            end
          end

          S_LOAD: begin
            if (load_last) begin
              state <= S_LOADED;
            end
          end

          S_LOADED: begin
            w_done <= 1'b1;
            state  <= S_KICK;
          end

          // First layer always reads ram_t0; later layers alternate banks.
          S_KICK: begin
            conv_en  <= 1'b1;
            src_bank <= (layer_idx == '0) ? 1'b0 : ~src_bank;
            state    <= S_RUN;
          end

          S_RUN: begin
            if (conv_done) begin
              if (layer_idx == layer_cnt - LAYER_W'(1)) begin
                state <= S_FIN;
              end else begin
                layer_idx <= layer_idx + LAYER_W'(1);
                state     <= S_KICK;
              end
            end
          end

          S_FIN: begin
            done  <= 1'b1;
            state <= S_RDWAIT;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// tb_layer_seq_ctrl: directed and randomized runs of layer_seq_ctrl. Expected
// pulse times, bank/index values and flags are derived arithmetically from
// the event times the bench itself drives.
module tb_layer_seq_ctrl;
  localparam int unsigned LAYER_W = 4;

  logic               clk = 1'b0;
  logic               rstn, enable, start, load_last, conv_done, rd_req, rd_last;
  logic [LAYER_W-1:0] num_layers;
  logic               w_done, conv_en, src_bank, busy, rd_grant, done, err;
  logic [LAYER_W-1:0] layer_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(.LAYER_W(LAYER_W)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .start(start),
    .num_layers(num_layers), .load_last(load_last), .conv_done(conv_done),
    .rd_req(rd_req), .rd_last(rd_last), .w_done(w_done), .conv_en(conv_en),
    .src_bank(src_bank), .layer_idx(layer_idx), .busy(busy),
    .rd_grant(rd_grant), .done(done), .err(err)
  );

  // One clock: inputs set after this return are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w_done"},   32'(w_done),    32'(0));
    chk({tag, "_conv_en"},  32'(conv_en),   32'(0));
    chk({tag, "_src_bank"}, 32'(src_bank),  32'(0));
    chk({tag, "_idx"},      32'(layer_idx), 32'(0));
    chk({tag, "_busy"},     32'(busy),      32'(0));
    chk({tag, "_rd_grant"}, 32'(rd_grant),  32'(0));
    chk({tag, "_done"},     32'(done),      32'(0));
    chk({tag, "_err"},      32'(err),       32'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    exp_err = 1'b0;
    chk_all_zero("reset");
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("quiet_pulses", 32'({w_done, conv_en, done}), 32'(0));
    end
  endtask

  // One full run. stall_len>0 drops enable while layer 1 sits in KICK;
  // spur injects a conv_done during LOAD and a start during RUN;
  // abort_layer>=0 asserts reset right after that layer's conv_en.
  task automatic run_seq(input int nl, input int load_dly, input int lat_lo,
                         input int lat_hi, input int stall_len, input bit spur,
                         input int abort_layer);
    int n_en, n_wd, exp_wd, exp_en, exp_done, cd_tick, st_from, sp_tick, t_ld;
    bit finished;
    n_en = 0; n_wd = 0; exp_done = -1; cd_tick = -1; st_from = -1;
    sp_tick = -1; finished = 1'b0;

    num_layers = LAYER_W'(nl);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));

    for (int i = 0; i < load_dly; i++) begin
      conv_done = spur && (i == 0);
      if (conv_done) exp_err = 1'b1;
      tick();
      conv_done = 1'b0;
    end

    load_last = 1'b1;
    t_ld = cyc;
    tick();
    load_last = 1'b0;
    exp_wd = t_ld + 2;
    exp_en = t_ld + 3;

    for (int guard = 0; guard < 3000 && !finished; guard++) begin
      if (w_done) begin
        n_wd++;
        chk("w_done_time", 32'(cyc), 32'(exp_wd));
      end
      if (st_from >= 0 && cyc >= st_from && cyc < st_from + stall_len) begin
        chk("stall_layer_idx", 32'(layer_idx), 32'(1));
        chk("stall_src_bank", 32'(src_bank), 32'(0));
      end
      if (conv_en) begin
        chk("conv_en_time", 32'(cyc), 32'(exp_en));
        chk("src_bank", 32'(src_bank), 32'(n_en % 2));
        chk("layer_idx", 32'(layer_idx), 32'(n_en));
        n_en++;
        if (abort_layer == n_en - 1) begin
          rstn = 1'b1;
          tick();
          rstn = 1'b0;
          exp_err = 1'b0;
          chk_all_zero("abort");
          return;
        end
        cd_tick = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (spur && n_en == 1) sp_tick = cyc + 1;
      end
      if (done) begin
        chk("done_time", 32'(cyc), 32'(exp_done));
        finished = 1'b1;
      end
      if (!finished) begin
        enable = !(st_from >= 0 && cyc >= st_from && cyc < st_from + stall_len);
        start = (cyc == sp_tick);
        if (start) begin
          exp_err = 1'b1;
          num_layers = LAYER_W'(5);
        end
        conv_done = (cyc == cd_tick);
        if (conv_done) begin
          if (n_en < nl) begin
            exp_en = cyc + 2;
            if (stall_len > 0 && n_en == 1) begin
              st_from = cyc + 1;
              exp_en += stall_len;
            end
          end else begin
            exp_done = cyc + 2;
          end
        end
        tick();
        start = 1'b0;
        conv_done = 1'b0;
      end
    end
    enable = 1'b1;
    chk("run_finished", 32'(finished), 32'(1));
    chk("conv_en_count", 32'(n_en), 32'(nl));
    chk("w_done_count", 32'(n_wd), 32'(1));
    chk("busy_at_done", 32'(busy), 32'(1));
    chk("err_at_done", 32'(err), 32'(exp_err));
  endtask

  task automatic readback(input int gap);
    rd_req = 1'b1;
    tick();
    chk("rd_grant_rise", 32'(rd_grant), 32'(1));
    for (int i = 1; i < gap; i++) begin
      tick();
      chk("rd_grant_hold", 32'(rd_grant), 32'(1));
      chk("busy_in_rd", 32'(busy), 32'(1));
    end
    rd_last = 1'b1;
    tick();
    rd_last = 1'b0;
    rd_req = 1'b0;
    chk("rd_grant_drop", 32'(rd_grant), 32'(0));
    chk("busy_after_rd", 32'(busy), 32'(0));
    chk("err_after_rd", 32'(err), 32'(exp_err));
  endtask

  task automatic zero_start();
    num_layers = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_busy", 32'(busy), 32'(0));
    chk("zero_no_kick", 32'({w_done, conv_en}), 32'(0));
    tick();
    chk("zero_done_once", 32'(done), 32'(0));
    chk("zero_busy2", 32'(busy), 32'(0));
    chk("zero_err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    rstn = 1'b1; enable = 1'b1; start = 1'b0; load_last = 1'b0;
    conv_done = 1'b0; rd_req = 1'b0; rd_last = 1'b0; num_layers = '0;

    do_reset();

    // Three layers, load_last after 9 idle load cycles, 20-cycle layers.
    run_seq(3, 9, 20, 20, 0, 1'b0, -1);
    quiet(2);
    readback(8);

    zero_start();

    // Enable stall while layer 1 waits in KICK.
    run_seq(3, 2, 4, 8, 5, 1'b0, -1);
    readback(3);

    // Spurious conv_done in LOAD and start in RUN; err sticky.
    run_seq(2, 5, 3, 10, 0, 1'b1, -1);
    readback(4);
    zero_start();
    chk("err_sticky", 32'(err), 32'(1));

    // Reset mid-run during layer 1, then a clean single-layer run.
    do_reset();
    run_seq(3, 4, 6, 6, 0, 1'b0, 1);
    run_seq(1, 3, 5, 5, 0, 1'b0, -1);
    readback(2);

    // Randomized runs; some restart straight from RDWAIT.
    for (int r = 0; r < 8; r++) begin
      run_seq(int'($urandom_range(8, 1)), int'($urandom_range(12, 0)), 0,
              int'($urandom_range(15, 1)), int'($urandom_range(3, 0)), 1'b0, -1);
      quiet(1);
      if ($urandom_range(1, 0) == 1) readback(int'($urandom_range(6, 1)));
    end

    // rd_last with no grant is a violation.
    do_reset();
    rd_last = 1'b1;
    tick();
    rd_last = 1'b0;
    exp_err = 1'b1;
    chk("rd_last_no_grant_err", 32'(err), 32'(exp_err));
    chk("rd_last_no_grant_busy", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
